// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// regfile_sb_if : decode/writeback bus of the regfile_sb register file
// Rev 1.0
// ============================================================================
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG)
);
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                we;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     indata;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic                ready;

  modport master (
    output rs_addr, iss_valid, iss_rd, we, rd, indata, dbg_addr,
    input  rs_data, rs_busy, dbg_data, ready
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, we, rd, indata, dbg_addr,
    output rs_data, rs_busy, dbg_data, ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : register file with NRP read ports, pending-write scoreboard,
// post-reset clear pass and registered debug read. Option: REGFILE_BYPASS_EN.
// Rev 1.0
// ============================================================================
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  localparam logic [AW:0]   c_nreg = (AW+1)'(NREG);
  localparam logic [AW-1:0] c_last = AW'(NREG - 1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] dbg_q;
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic            wr_en;
  logic            iss_en;

  // Entry 0 and addresses past the populated range behave as constant zero
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < c_nreg);
  endfunction

  assign wr_en  = (state_q == RUN) && bus.we && in_range(bus.rd);
  assign iss_en = (state_q == RUN) && bus.iss_valid && in_range(bus.iss_rd);

  // A new producer issued in the same cycle as the old one retires keeps the bit set
  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[bus.rd]     = 1'b0;
    if (iss_en) pend_d[bus.iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      dbg_q   <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_last) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          pend_q <= pend_d;
          dbg_q  <= in_range(bus.dbg_addr) ? rf_q[bus.dbg_addr] : '0;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT pass clears it one entry per cycle
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      rf_q[cnt_q] <= '0;
    end else if (wr_en) begin
      rf_q[bus.rd] <= bus.indata;
    end
  end

  generate
    for (genvar k = 0; k < NRP; k++) begin : g_rd_port
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = bus.rs_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign hit = wr_en && (bus.rd == addr);
`else
      assign hit = 1'b0;
`endif
      assign bus.rs_data[k*XLEN +: XLEN] = (!ready_q || !in_range(addr)) ? '0 :
                                           hit ? bus.indata : rf_q[addr];
      assign bus.rs_busy[k] = ready_q && in_range(addr) && !hit && pend_q[addr];
    end
  endgenerate

  assign bus.ready    = ready_q;
  assign bus.dbg_data = dbg_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : directed bench for regfile_sb (32x2 and 24x3 instances)
// Rev 1.0
// ============================================================================
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc;
  int   rb;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NRP(2), .AW(5)) bus_a ();
  regfile_sb_if #(.XLEN(32), .NREG(24), .NRP(3), .AW(5)) bus_b ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .AW(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  regfile_sb #(.XLEN(32), .NREG(24), .NRP(3), .AW(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.rs_addr = '0; bus_a.iss_valid = 1'b0; bus_a.iss_rd = '0;
    bus_a.we = 1'b0; bus_a.rd = '0; bus_a.indata = '0; bus_a.dbg_addr = '0;
    bus_b.rs_addr = '0; bus_b.iss_valid = 1'b0; bus_b.iss_rd = '0;
    bus_b.we = 1'b0; bus_b.rd = '0; bus_b.indata = '0; bus_b.dbg_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", bus_a.ready, 0);
    check_eq("rst_dbg", bus_a.dbg_data, 0);
    check_eq("rst_busy", bus_a.rs_busy, 0);

    // Clear pass latency: ready seen after NREG edges
    rst_n = 1'b1;
    cyc = 0;
    rb = 0;
    while (!bus_a.ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_b.ready && rb == 0) rb = cyc;
    end
    check_eq("ready_lat_a", cyc, 32);
    check_eq("ready_lat_b", rb, 24);

    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      bus_a.rs_addr = {5'(r), 5'(31 - r)};
      #1;
      check_eq("clear_p0", bus_a.rs_data[31:0], 0);
      check_eq("clear_p1", bus_a.rs_data[63:32], 0);
    end
    check_eq("clear_dbg", bus_a.dbg_data, 0);

    // Write x5, both ports reading it
    @(negedge clk);
    bus_a.we = 1'b1; bus_a.rd = 5'd5; bus_a.indata = 32'hDEADBEEF;
    bus_a.rs_addr = {5'd5, 5'd5};
    #1;
    check_eq("wr5_same", bus_a.rs_data[31:0], c_byp ? 32'hDEADBEEF : 32'h0);
    @(negedge clk);
    bus_a.we = 1'b0;
    #1;
    check_eq("wr5_p0", bus_a.rs_data[31:0], 32'hDEADBEEF);
    check_eq("wr5_p1", bus_a.rs_data[63:32], 32'hDEADBEEF);

    // Write to x0 is dropped
    bus_a.we = 1'b1; bus_a.rd = 5'd0; bus_a.indata = 32'h1234;
    bus_a.rs_addr = {5'd0, 5'd0};
    #1;
    check_eq("wr0_same", bus_a.rs_data[31:0], 0);
    @(negedge clk);
    bus_a.we = 1'b0;
    #1;
    check_eq("wr0_after", bus_a.rs_data[31:0], 0);

    // Scoreboard on x7
    bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd7; bus_a.rs_addr = {5'd7, 5'd7};
    #1;
    check_eq("iss7_same", bus_a.rs_busy, 2'b00);
    @(negedge clk);
    bus_a.iss_valid = 1'b0;
    #1;
    check_eq("iss7_busy", bus_a.rs_busy, 2'b11);
    bus_a.we = 1'b1; bus_a.rd = 5'd7; bus_a.indata = 32'h77;
    #1;
    check_eq("wb7_same", bus_a.rs_busy, c_byp ? 2'b00 : 2'b11);
    @(negedge clk);
    bus_a.we = 1'b0;
    #1;
    check_eq("wb7_clear", bus_a.rs_busy, 2'b00);
    check_eq("wb7_data", bus_a.rs_data[63:32], 32'h77);
    bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd7;
    bus_a.we = 1'b1; bus_a.rd = 5'd7; bus_a.indata = 32'h78;
    @(negedge clk);
    bus_a.iss_valid = 1'b0; bus_a.we = 1'b0;
    #1;
    check_eq("iss_wb7_set_wins", bus_a.rs_busy, 2'b11);

    // Forwarding window on x3
    bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd3;
    @(negedge clk);
    bus_a.iss_valid = 1'b0;
    bus_a.rs_addr = {5'd3, 5'd0};
    bus_a.we = 1'b1; bus_a.rd = 5'd3; bus_a.indata = 32'hA5A5A5A5;
    #1;
    check_eq("byp3_data", bus_a.rs_data[63:32], c_byp ? 32'hA5A5A5A5 : 32'h0);
    check_eq("byp3_busy", bus_a.rs_busy[1], c_byp ? 1'b0 : 1'b1);
    @(negedge clk);
    bus_a.we = 1'b0;
    #1;
    check_eq("wr3_data", bus_a.rs_data[63:32], 32'hA5A5A5A5);
    check_eq("wr3_busy", bus_a.rs_busy[1], 1'b0);

    bus_a.dbg_addr = 5'd5;
    @(negedge clk);
    #1;
    check_eq("dbg5", bus_a.dbg_data, 32'hDEADBEEF);

    // Smaller file: out-of-range addresses and debug
    bus_b.we = 1'b1; bus_b.rd = 5'd23; bus_b.indata = 32'hCAFEF00D;
    @(negedge clk);
    bus_b.rd = 5'd24; bus_b.indata = 32'h11111111;
    @(negedge clk);
    bus_b.rd = 5'd31; bus_b.indata = 32'h22222222;
    bus_b.iss_valid = 1'b1; bus_b.iss_rd = 5'd24;
    @(negedge clk);
    bus_b.we = 1'b0; bus_b.iss_valid = 1'b0;
    bus_b.rs_addr = {5'd23, 5'd31, 5'd24};
    bus_b.dbg_addr = 5'd23;
    #1;
    check_eq("b_p0_addr24", bus_b.rs_data[31:0], 0);
    check_eq("b_p1_addr31", bus_b.rs_data[63:32], 0);
    check_eq("b_p2_addr23", bus_b.rs_data[95:64], 32'hCAFEF00D);
    check_eq("b_busy", bus_b.rs_busy, 3'b000);
    @(negedge clk);
    bus_b.dbg_addr = 5'd24;
    #1;
    check_eq("b_dbg23", bus_b.dbg_data, 32'hCAFEF00D);
    @(negedge clk);
    #1;
    check_eq("b_dbg24", bus_b.dbg_data, 0);

    // Reset in the middle of RUN
    bus_a.we = 1'b1; bus_a.rd = 5'd9; bus_a.indata = 32'h55;
    bus_a.iss_valid = 1'b1; bus_a.iss_rd = 5'd9;
    @(negedge clk);
    bus_a.we = 1'b0; bus_a.iss_valid = 1'b0;
    bus_a.rs_addr = {5'd9, 5'd9};
    #1;
    check_eq("x9_data", bus_a.rs_data[31:0], 32'h55);
    check_eq("x9_busy", bus_a.rs_busy, 2'b11);
    check_eq("pre_rst_dbg", bus_a.dbg_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", bus_a.ready, 0);
    check_eq("mid_rst_busy", bus_a.rs_busy, 2'b00);
    check_eq("mid_rst_dbg", bus_a.dbg_data, 0);
    check_eq("mid_rst_data", bus_a.rs_data[31:0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!bus_a.ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reinit_lat", cyc, 32);
    #1;
    check_eq("x9_cleared", bus_a.rs_data[31:0], 0);
    check_eq("x9_not_busy", bus_a.rs_busy, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
